// File: rtl/stage_m.sv
// stage_m: memory stage of the combined ARM/RISC-V pipeline.
// Holds the E/M pipeline register, runs a single-outstanding req/ack data
// bus with byte-lane enables and store-data replication, and extends load
// data for writeback.
// Optional build macro: LSU_TIMEOUT_EN adds a bus-wait timeout that aborts
// a stuck access after TIMEOUT_CYCLES wait cycles and pulses BusErrM.
module stage_m #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // execute-stage inputs
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  RdE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  ResultSrcE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  MemSizeE,
  input  logic        MemSignedE,
  input  logic        armE,
  input  logic        FlushM,
  // pass-through to writeback / forwarding
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic [31:0] PCPlus4M,
  output logic [1:0]  ResultSrcM,
  output logic        RegWriteM,
  output logic        armM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  // data bus
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack
);

  // E/M pipeline register contents
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [1:0]  rsrc;
    logic        rw;
    logic        mw;
    logic [1:0]  size;
    logic        sgn;
    logic        arm;
  } em_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  // A timeout of zero cycles would abort before the bus is ever sampled.
  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("stage_m: TIMEOUT_CYCLES must be at least 1");
  end

  // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return |lo;
    endcase
  endfunction

  em_t    em_q, em_d, em_in;
  state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic memop_e, aligned_e, load_go;
  logic memop_m, mis_m;
  logic in_req, in_resp;
  logic timeout_hit;
  logic bus_err;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] ext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign em_in = '{alu:   ALUResultE,
                   wdata: WriteDataE,
                   rd:    RdE,
                   pc4:   PCPlus4E,
                   rsrc:  ResultSrcE,
                   rw:    RegWriteE,
                   mw:    MemWriteE,
                   size:  MemSizeE,
                   sgn:   MemSignedE,
                   arm:   armE};

  assign memop_e   = MemWriteE | (ResultSrcE == 2'b01);
  assign aligned_e = ~is_misaligned(MemSizeE, ALUResultE[1:0]);
  // an access starts only when an aligned memop is actually loaded (not flushed)
  assign load_go   = memop_e & aligned_e & ~FlushM;

  assign memop_m = em_q.mw | (em_q.rsrc == 2'b01);
  assign mis_m   = is_misaligned(em_q.size, em_q.alu[1:0]);
  assign in_req  = (state_q == S_REQ);
  assign in_resp = (state_q == S_RESP);

  // E/M register next value: flush beats hold, hold beats load
  always_comb begin
    em_d = em_q;
    if (FlushM)      em_d = '0;
    else if (!in_req) em_d = em_in;
  end

  // E/M register and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q    <= '0;
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      em_q    <= em_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // FSM next state; flush in REQ is illegal but recovers to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: state_d = load_go ? S_REQ : S_IDLE;
      S_REQ: begin
        if (FlushM)           state_d = S_IDLE;
        else if (dack)        state_d = S_RESP;
        else if (timeout_hit) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // byte-lane enables for the access in M
  always_comb begin
    case (em_q.size)
      2'b00:   be = 4'b0001 << em_q.alu[1:0];
      2'b01:   be = 4'b0011 << {em_q.alu[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  // store data replicated onto every lane it could land in
  always_comb begin
    case (em_q.size)
      2'b00:   wd = {4{em_q.wdata[7:0]}};
      2'b01:   wd = {2{em_q.wdata[15:0]}};
      default: wd = em_q.wdata;
    endcase
  end

  assign byte_lane = drdata[{em_q.alu[1:0], 3'b000} +: 8];
  assign half_lane = drdata[{em_q.alu[1], 4'b0000} +: 16];

  // pick the addressed lane and sign/zero-extend it
  always_comb begin
    case (em_q.size)
      2'b00:   ext = {{24{em_q.sgn & byte_lane[7]}}, byte_lane};
      2'b01:   ext = {{16{em_q.sgn & half_lane[15]}}, half_lane};
      default: ext = drdata;
    endcase
  end

  // load data captured on ack, zeroed on abort, held otherwise
  always_comb begin
    rdata_d = rdata_q;
    if (in_req && !FlushM) begin
      if (dack)             rdata_d = ext;
      else if (timeout_hit) rdata_d = '0;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // abort on the TIMEOUT_CYCLES-th consecutive wait cycle
  assign timeout_hit = in_req & ~dack & ~FlushM & (cnt_q == CNT_LAST);

  // wait counter is zero outside REQ, so it starts clean on every entry
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (!in_req)   cnt_d = '0;
    else if (!dack) cnt_d = cnt_q + CNT_W'(1);
    if (timeout_hit) err_d = 1'b1;
  end

  // timeout counter and aborted-access flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err = in_resp & err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // bus drive; fields are gated so the bus is quiet when no request is up
  assign dreq   = in_req;
  assign dwe    = in_req & em_q.mw;
  assign daddr  = in_req ? {em_q.alu[31:2], 2'b00} : 32'h0;
  assign dbe    = in_req ? be : 4'b0000;
  assign dwdata = in_req ? wd : 32'h0;

  assign StallM    = in_req;
  assign MisalignM = memop_m & mis_m;
  assign BusErrM   = bus_err;
  assign ReadDataM = rdata_q;

  assign ALUResultM = em_q.alu;
  assign RdM        = em_q.rd;
  assign PCPlus4M   = em_q.pc4;
  assign ResultSrcM = em_q.rsrc;
  assign armM       = em_q.arm;
  // faulted ops must never write the register file
  assign RegWriteM  = em_q.rw & ~MisalignM & ~bus_err;

endmodule

// File: tb/tb_stage_m.sv
// tb_stage_m: directed + randomized bench for stage_m with a behavioural
// reference model of lane selection, replication, extension and latency.
module tb_stage_m;

  logic        clk, rst_n;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ResultSrcE, MemSizeE;
  logic        RegWriteE, MemWriteE, MemSignedE, armE, FlushM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic        RegWriteM, armM, StallM, MisalignM, BusErrM;
  logic        dreq, dwe, dack;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;

  stage_m #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .armE(armE), .FlushM(FlushM),
    .ALUResultM(ALUResultM), .RdM(RdM), .PCPlus4M(PCPlus4M), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .armM(armM), .ReadDataM(ReadDataM), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata),
    .drdata(drdata), .dack(dack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, wd, pc, rdat;
    logic [4:0]  rd;
    logic [1:0]  rs, sz;
    logic        rw, mw, sg, arm;
    int          wt;
  } op_t;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] rd_last = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_mem(input op_t o);
    return o.mw || (o.rs == 2'b01);
  endfunction

  function automatic bit misal(input op_t o);
    return (o.a % nbytes(o.sz)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input op_t o);
    logic [3:0] r;
    int off = int'(o.a % 4);
    int n = nbytes(o.sz);
    for (int b = 0; b < 4; b++) r[b] = (b >= off) && (b < off + n);
    return r;
  endfunction

  function automatic logic [31:0] exp_wd(input op_t o);
    logic [31:0] r;
    int n = nbytes(o.sz);
    for (int b = 0; b < 4; b++) r[8*b +: 8] = o.wd[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input op_t o);
    logic [63:0] v, m;
    int n = nbytes(o.sz);
    int off = int'(o.a % 4);
    if (n == 4) return o.rdat;
    v = {32'h0, o.rdat} >> (8 * off);
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (o.sg && (((v >> (8 * n - 1)) & 64'd1) == 64'd1)) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic drive_e(input op_t o);
    ALUResultE = o.a;  WriteDataE = o.wd; RdE = o.rd; PCPlus4E = o.pc;
    ResultSrcE = o.rs; RegWriteE = o.rw;  MemWriteE = o.mw;
    MemSizeE = o.sz;   MemSignedE = o.sg; armE = o.arm;
  endtask

  task automatic launch(input op_t o);
    drive_e(o);
    @(posedge clk); #1;
  endtask

  task automatic mk_alu(output op_t o);
    o = '{a:$urandom, wd:$urandom, pc:$urandom, rdat:32'h0, rd:5'($urandom),
          rs:2'b00, sz:2'($urandom), rw:1'b1, mw:1'b0, sg:1'b0, arm:1'($urandom), wt:0};
  endtask

  task automatic mk_rnd(output op_t o);
    o.sz = 2'($urandom);
    o.a  = $urandom;
    if ($urandom_range(0, 4) != 0) o.a = o.a & ~(32'(nbytes(o.sz)) - 32'd1);
    o.mw = ($urandom_range(0, 3) == 0);
    o.rs = 2'($urandom_range(0, 2));
    o.rw = 1'($urandom); o.sg = 1'($urandom); o.arm = 1'($urandom);
    o.rd = 5'($urandom); o.pc = $urandom; o.wd = $urandom; o.rdat = $urandom;
    o.wt = $urandom_range(0, 3);
  endtask

  // op o was just loaded into M; drive nxt on E and follow o until nxt is in M
  task automatic service(input op_t o, input op_t nxt);
    drive_e(nxt);
    dack = 1'b0;
    chk("alu_pass", ALUResultM, o.a);
    chk("rd_pass", 32'(RdM), 32'(o.rd));
    chk("pc4_pass", PCPlus4M, o.pc);
    chk("rsrc_pass", 32'(ResultSrcM), 32'(o.rs));
    chk("arm_pass", 32'(armM), 32'(o.arm));
    chk("buserr_idle", 32'(BusErrM), 32'd0);
    if (is_mem(o) && !misal(o)) begin
      for (int k = 0; k <= o.wt; k++) begin
        chk("dreq_req", 32'(dreq), 32'd1);
        chk("stall_req", 32'(StallM), 32'd1);
        chk("daddr", daddr, o.a & 32'hFFFF_FFFC);
        chk("dbe", 32'(dbe), 32'(exp_be(o)));
        chk("dwe", 32'(dwe), 32'(o.mw));
        chk("dwdata", dwdata, o.mw ? exp_wd(o) : dwdata);
        if (o.mw) chk("dwdata_st", dwdata, exp_wd(o));
        dack   = (k == o.wt);
        drdata = (k == o.wt) ? o.rdat : $urandom;
        @(posedge clk); #1;
      end
      dack = 1'b0; drdata = $urandom;
      rd_last = exp_ld(o);
      chk("dreq_resp", 32'(dreq), 32'd0);
      chk("stall_resp", 32'(StallM), 32'd0);
      chk("rdata", ReadDataM, rd_last);
      chk("regwrite_resp", 32'(RegWriteM), 32'(o.rw));
      chk("misalign_resp", 32'(MisalignM), 32'd0);
    end else begin
      chk("dreq_quiet", 32'(dreq), 32'd0);
      chk("stall_quiet", 32'(StallM), 32'd0);
      chk("misalign", 32'(MisalignM), 32'(is_mem(o) && misal(o)));
      chk("regwrite", 32'(RegWriteM), (is_mem(o) && misal(o)) ? 32'd0 : 32'(o.rw));
      chk("rdata_hold", ReadDataM, rd_last);
      // a stray ack outside an access must be ignored
      dack = 1'($urandom); drdata = $urandom;
    end
    @(posedge clk); #1;
    dack = 1'b0;
  endtask

  op_t d1, d2, d3, d4, d5, alu, cur, nx, zero_op;

  initial begin
    rst_n = 1'b1; FlushM = 1'b0; dack = 1'b0; drdata = 32'h0;
    mk_alu(alu);
    drive_e(alu);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dreq", 32'(dreq), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_alu", ALUResultM, 32'd0);
    chk("rst_regwrite", 32'(RegWriteM), 32'd0);
    chk("rst_misalign", 32'(MisalignM), 32'd0);
    chk("rst_buserr", 32'(BusErrM), 32'd0);
    chk("rst_dbe", 32'(dbe), 32'd0);
    #5 rst_n = 1'b1;

    // directed: signed byte load, half store with waits, misaligned word,
    // then back-to-back word and unsigned half loads
    d1 = '{a:32'h103, wd:32'h0, pc:32'h44, rdat:32'h80FF_1234, rd:5'd3,
           rs:2'b01, sz:2'b00, rw:1'b1, mw:1'b0, sg:1'b1, arm:1'b0, wt:0};
    d2 = '{a:32'h202, wd:32'h1234_ABCD, pc:32'h48, rdat:32'h5555_AAAA, rd:5'd0,
           rs:2'b00, sz:2'b01, rw:1'b0, mw:1'b1, sg:1'b0, arm:1'b1, wt:3};
    d3 = '{a:32'h301, wd:32'h0, pc:32'h4C, rdat:32'h0, rd:5'd7,
           rs:2'b01, sz:2'b10, rw:1'b1, mw:1'b0, sg:1'b0, arm:1'b0, wt:0};
    d4 = '{a:32'h10, wd:32'h0, pc:32'h50, rdat:32'hDEAD_BEEF, rd:5'd8,
           rs:2'b01, sz:2'b10, rw:1'b1, mw:1'b0, sg:1'b0, arm:1'b0, wt:0};
    d5 = '{a:32'h16, wd:32'h0, pc:32'h54, rdat:32'hF00D_1234, rd:5'd9,
           rs:2'b01, sz:2'b01, rw:1'b1, mw:1'b0, sg:1'b0, arm:1'b1, wt:0};
    launch(d1);
    chk("t1_dbe", 32'(dbe), 32'b1000);
    chk("t1_daddr", daddr, 32'h100);
    service(d1, d2);
    chk("t1_rdata", ReadDataM, 32'hFFFF_FF80);
    chk("t2_dwdata", dwdata, 32'hABCD_ABCD);
    service(d2, d3);
    service(d3, d4);
    service(d4, d5);
    chk("t4_b2b_dreq", 32'(dreq), 32'd1);
    service(d5, alu);
    chk("t4_rdata", ReadDataM, 32'h0000_F00D);

    // randomized chain
    cur = alu;
    for (int i = 0; i < 60; i++) begin
      mk_rnd(nx);
      service(cur, nx);
      cur = nx;
    end
    mk_alu(alu);
    service(cur, alu);

    // flush clears the register before a memop can start
    zero_op = '{a:32'h0, wd:32'h0, pc:32'h0, rdat:32'h0, rd:5'd0,
                rs:2'b00, sz:2'b00, rw:1'b0, mw:1'b0, sg:1'b0, arm:1'b0, wt:0};
    drive_e(d4); FlushM = 1'b1;
    @(posedge clk); #1;
    FlushM = 1'b0;
    chk("flush_dreq", 32'(dreq), 32'd0);
    chk("flush_alu", ALUResultM, 32'd0);
    chk("flush_rd", 32'(RdM), 32'd0);
    service(zero_op, d4);
    service(d4, alu);

    // reset during REQ drops the request without a clock edge
    launch(d2);
    drive_e(alu);
    chk("pre_rst_dreq", 32'(dreq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dreq", 32'(dreq), 32'd0);
    chk("mid_rst_dwe", 32'(dwe), 32'd0);
    chk("mid_rst_stall", 32'(StallM), 32'd0);
    chk("mid_rst_rdata", ReadDataM, 32'd0);
    chk("mid_rst_alu", ALUResultM, 32'd0);
    chk("mid_rst_pc4", PCPlus4M, 32'd0);
    #2 rst_n = 1'b1;
    rd_last = 32'h0;
    @(posedge clk); #1;
    service(alu, d1);
    service(d1, alu);

`ifdef LSU_TIMEOUT_EN
    // no ack ever: abort after 4 wait cycles
    launch(d4);
    drive_e(alu);
    for (int k = 0; k < 4; k++) begin
      chk("to_stall", 32'(StallM), 32'd1);
      chk("to_dreq", 32'(dreq), 32'd1);
      @(posedge clk); #1;
    end
    rd_last = 32'h0;
    chk("to_buserr", 32'(BusErrM), 32'd1);
    chk("to_rdata", ReadDataM, 32'd0);
    chk("to_regwrite", 32'(RegWriteM), 32'd0);
    chk("to_stall_rel", 32'(StallM), 32'd0);
    chk("to_dreq_low", 32'(dreq), 32'd0);
    @(posedge clk); #1;
    service(alu, alu);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage_m.md
# stage_m

Memory stage of the combined ARM/RISC-V pipeline, directly downstream of the execute stage. Holds the E/M pipeline register, drives a single-outstanding request/acknowledge data-memory bus with byte-lane generation and store-data replication, and produces sign- or zero-extended load data for writeback. Raises `StallM` to the hazard unit while an access is outstanding. Passes `ALUResultM` back to execute for forwarding.

## Interface
- `TIMEOUT_CYCLES`, default 255: wait-cycle limit before a bus access is aborted. Used only with `LSU_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ALUResultE`, `WriteDataE` in 32: address or ALU result, and store data.
- `RdE` in 5; `PCPlus4E` in 32; `ResultSrcE` in 2; `RegWriteE`, `MemWriteE` in 1; `MemSizeE` in 2; `MemSignedE` in 1; `armE` in 1.
- `FlushM` in 1: hazard-unit flush; clears the E/M register at the next edge.
- `ALUResultM` out 32, `RdM` out 5, `PCPlus4M` out 32, `ResultSrcM` out 2, `RegWriteM` out 1, `armM` out 1: registered pass-through to writeback and forwarding.
- `ReadDataM` out 32: extended load data.
- `StallM` out 1: hold E/M and upstream stages.
- `MisalignM`, `BusErrM` out 1: single-cycle fault pulses.
- `dreq` out 1, `dwe` out 1, `daddr` out 32, `dbe` out 4, `dwdata` out 32: data bus request.
- `drdata` in 32, `dack` in 1: data bus response.

## Operation
- **Memory op.** `memop = MemWrite | (ResultSrc == 2'b01)`. A load is a memop with `MemWrite = 0`.
- **E/M register.**
  - Loads all E inputs at each edge when `StallM = 0`.
  - Holds when `StallM = 1`.
  - Clears when `FlushM = 1`. Flush has priority over hold.
- **MemSize encoding.** 00 = byte, 01 = half, 10 or 11 = word.
- **Alignment.** Misaligned means half with `addr[0] = 1`, or word with `addr[1:0] != 0`.
  - On a misaligned memop: no bus request, `MisalignM = 1` for that cycle, `RegWriteM` forced 0, `StallM = 0`.
- **Byte enables.**
  - Byte: `dbe = 4'b0001 << addr[1:0]`.
  - Half: `dbe = 4'b0011 << {addr[1], 1'b0}`.
  - Word: `dbe = 4'b1111`.
- **Store data.** `dwdata` = byte replicated ×4, half replicated ×2, or the full word.
- **Address.** `daddr = ALUResultM` with the low 2 bits zeroed.
- **Load extract.** Select the lane `drdata >> (8*addr[1:0])` for byte, or `(16*addr[1])` for half. Sign-extend if `MemSigned`, otherwise zero-extend. The result is latched on `dack`.
- **FSM.**
  - IDLE:
    - `dreq = 0`.
    - At an edge loading an aligned memop, go to REQ.
  - REQ:
    - `dreq = 1`, `dwe = MemWriteM`, `StallM = 1`.
    - On `dack`: latch extracted data into `ReadDataM`, go to RESP.
  - RESP:
    - `dreq = 0`, `StallM = 0`.
    - `ReadDataM` is valid this cycle.
    - At the edge: go to REQ if the newly loaded op is an aligned memop, otherwise IDLE.
- **ReadDataM hold.** `ReadDataM` holds its last value outside RESP.
- **Flush during REQ.** Not allowed; the hazard unit must not flush M while `StallM = 1`. If it occurs anyway: the register clears, the FSM returns to IDLE, and `dreq` drops.

## Timing
- **Reset values.** All registered outputs are 0: `dreq`, `dwe`, `StallM`, `MisalignM`, `BusErrM`, `ReadDataM`, and all pass-throughs. FSM state is IDLE.
- **Reset mid-access.** `dreq` drops immediately (asynchronously).
- **Memop latency.** Minimum 2 cycles in M: one REQ cycle with `dack`, plus one RESP cycle. Each cycle without `dack` adds one stall cycle.
- **Non-memops.** Occupy M for 1 cycle; no stall.
- **Request stability.** While `dreq = 1`, `daddr`, `dbe`, `dwe` and `dwdata` are stable.
- **dack outside REQ.** Ignored.
- **Back-to-back memops.** RESP of op N followed by REQ of op N+1 gives exactly one `dreq`-low cycle between the two accesses.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - An 8-bit-or-wider counter clears on entering REQ and counts each REQ cycle without `dack`.
  - When the count reaches `TIMEOUT_CYCLES`:
    - Abort the access and go to RESP.
    - Set `ReadDataM = 0` and force `RegWriteM` to 0 for that op.
    - Pulse `BusErrM` for 1 cycle.
- **`LSU_TIMEOUT_EN` undefined:**
  - REQ waits indefinitely.
  - `BusErrM` is tied 0 and no counter exists.

## Test plan
- **Signed byte load.** Load with `ALUResultE = 0x103`, `MemSize = 00`, `MemSigned = 1`; `drdata = 0x80FF_1234`, `dack` in the first REQ cycle.
  - Bus: `dbe = 1000`, `daddr = 0x100`.
  - Result: `ReadDataM = 0xFFFF_FF80` in RESP; `StallM` high for exactly 1 cycle.
- **Half store.** `WriteData = 0x1234_ABCD`, addr `0x202`.
  - `dwe = 1`, `dbe = 1100`, `dwdata = 0xABCD_ABCD`.
  - `dack` after 3 wait cycles gives 4 stall cycles.
- **Misaligned word load.** Addr `0x301`.
  - No `dreq`; `MisalignM = 1` for 1 cycle; `RegWriteM = 0`; no stall.
- **Back-to-back loads.** Word load at `0x10`, then unsigned half load at `0x16`, both acked immediately.
  - Second `ReadDataM` = zero-extended `drdata[31:16]`.
  - Exactly one `dreq`-low cycle between the two requests.
- **Reset mid-REQ.** Assert `rst_n` low during REQ.
  - `dreq` drops without waiting for a clock edge; all outputs read 0.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES = 4`).** Never assert `dack`.
  - `BusErrM` pulses after 4 REQ cycles; `ReadDataM = 0`; `RegWriteM = 0`; pipeline resumes.
